// File: rtl/gpr_file.sv
// General-purpose register file: two combinational read ports, one writeback
// port with write-through bypass, and a pending-writeback scoreboard.
module gpr_file #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_addr,
  output logic              busy1,
  output logic              busy2
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;

  logic wr_en;
  logic pend_en;

  // Register 0 is hard-wired: writes and pending marks aimed at it are dropped.
  assign wr_en   = we       && (waddr     != '0);
  assign pend_en = pend_set && (pend_addr != '0);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    pend_d = pend_q;
    if (wr_en)   pend_d[waddr]     = 1'b0;
    // Applied after the clear so a new pending producer wins a same-address collision.
    if (pend_en) pend_d[pend_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // NOTE: the register array is reset on purpose -- the architecture demands every
  // register read 0 after reset, so it cannot map onto a reset-less RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on this edge consistent.
      if (wr_en) regs_q[waddr] <= wdata;
      pend_q <= pend_d;
    end
  end

  logic byp1, byp2;
  assign byp1 = wr_en && (waddr == raddr1);
  assign byp2 = wr_en && (waddr == raddr2);

  // Outputs are gated by rst_n so the bypass path cannot leak data during reset.
  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (rst_n && (raddr1 != '0)) begin
      rdata1 = byp1 ? wdata : regs_q[raddr1];
      busy1  = pend_q[raddr1] && !(byp1 && !(pend_en && (pend_addr == raddr1)));
    end
  end

  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (rst_n && (raddr2 != '0)) begin
      rdata2 = byp2 ? wdata : regs_q[raddr2];
      busy2  = pend_q[raddr2] && !(byp2 && !(pend_en && (pend_addr == raddr2)));
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        busy1, busy2;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  gpr_file #(.DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .pend_set(pend_set), .pend_addr(pend_addr), .busy1(busy1), .busy2(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Expected read data for an address given the current inputs and model state.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst_n || a == 0) return '0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n || a == 0) return 1'b0;
    if (we && waddr == a && !(pend_set && pend_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic ps, input logic [4:0] pa);
    we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
    pend_set = ps; pend_addr = pa;
  endtask

  task automatic check_ports(input string tag);
    check({tag, ".rd1"}, rdata1, exp_data(raddr1));
    check({tag, ".rd2"}, rdata2, exp_data(raddr2));
    check({tag, ".bz1"}, {31'b0, busy1}, {31'b0, exp_busy(raddr1)});
    check({tag, ".bz2"}, {31'b0, busy2}, {31'b0, exp_busy(raddr2)});
  endtask

  // Advance one clock edge, applying the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    // Reset with a would-be bypass and pending request active: outputs must stay 0.
    drive(1'b1, 5'd3, 32'hffff_ffff, 5'd3, 5'd3, 1'b1, 5'd3);
    #2;
    check("rst.rd1", rdata1, 32'h0);
    check("rst.bz1", {31'b0, busy1}, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    #1;
    check("rst.rd1_held", rdata1, 32'h0);
    rst_n = 1'b1;
    #1;
    check_ports("post_rst");
    tick();

    // Write then read back.
    drive(1'b1, 5'd5, 32'h00c0ffee, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    #3;
    check("wr_rd.data", rdata1, 32'h00c0ffee);
    check("wr_rd.busy", {31'b0, busy1}, 32'h0);
    tick();

    // Register 0 ignores writes.
    drive(1'b1, 5'd0, 32'hdeadbeef, 5'd0, 5'd0, 1'b0, 5'd0);
    #3;
    check("r0.before", rdata2, 32'h0);
    tick();
    #3;
    check("r0.after", rdata2, 32'h0);

    // Same-cycle write-through bypass.
    drive(1'b1, 5'd7, 32'hbaadc0de, 5'd7, 5'd0, 1'b0, 5'd0);
    #3;
    check("bypass", rdata1, 32'hbaadc0de);
    tick();

    // Scoreboard set / clear.
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    #3;
    check("sb.busy_set", {31'b0, busy1}, 32'h1);
    check("sb.busy_set2", {31'b0, busy2}, 32'h1);
    drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd0, 1'b0, 5'd0);
    #3;
    check("sb.wr_busy", {31'b0, busy1}, 32'h0);
    check("sb.wr_data", rdata1, 32'h1234);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    #3;
    check("sb.cleared", {31'b0, busy1}, 32'h0);
    tick();

    // Collision: pending producer wins, data still commits.
    drive(1'b1, 5'd9, 32'h5555, 5'd9, 5'd0, 1'b1, 5'd9);
    #3;
    check("coll.same_cycle_busy", {31'b0, busy1}, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    #3;
    check("coll.data", rdata1, 32'h5555);
    check("coll.busy", {31'b0, busy1}, 32'h1);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, pa, r1, r2;
      wa = 5'($urandom_range(0, 31));
      pa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, r1, r2,
            ($urandom_range(0, 2) == 0), pa);
      #3;
      check_ports($sformatf("rand%0d", n));
      tick();
    end

    // Populate everything, mark 3 pending, then reset between edges.
    for (int a = 1; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'ha5a5_0000 | 32'(a), 5'd0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd17, 1'b0, 5'd0);
    #3;
    check("pre_rst.busy3", {31'b0, busy1}, 32'h1);
    check("pre_rst.r17", rdata2, 32'ha5a5_0011);
    #1;
    rst_n = 1'b0;
    model_clear();
    #0.5;
    check("async.rd1", rdata1, 32'h0);
    check("async.bz1", {31'b0, busy1}, 32'h0);
    check("async.rd2", rdata2, 32'h0);
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'hffff_ffff, 5'(a), 5'(31 - a), 1'b1, 5'(a));
      #1;
      check_ports($sformatf("in_rst%0d", a));
    end
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0, 5'd0);
      #1;
      check($sformatf("post_rst_rd%0d", a), rdata1, 32'h0);
      check($sformatf("post_rst_bz%0d", a), {31'b0, busy1}, 32'h0);
    end
    tick();

    // Short random burst after reset recovery.
    for (int n = 0; n < 100; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
      #3;
      check_ports($sformatf("rand_b%0d", n));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 Parameter: DATA_W, 32, register and data width.
REQ-002 Parameter: NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: we  input  1  write enable for the writeback port, driven from the GPR write-data selector path.
REQ-006 Port: waddr  input  5  destination register for the write.
REQ-007 Port: wdata  input  32  write data (ALU result, memory data or PC+4, already selected upstream).
REQ-008 Port: raddr1 / raddr2  input  5 each  read port addresses (rs, rt).
REQ-009 Port: rdata1 / rdata2  output  32 each  read data, combinational.
REQ-010 Port: pend_set  input  1  mark a register as awaiting a pending (e.g. load) writeback.
REQ-011 Port: pend_addr  input  5  register to mark pending.
REQ-012 Port: busy1 / busy2  output  1 each  the corresponding read register holds a value not yet written back.

Function
REQ-013 Storage SHALL be NREGS x DATA_W flops plus an NREGS-bit pending scoreboard.
REQ-014 Write SHALL commit wdata into register waddr on the rising clk edge when we=1 and waddr!=0.
REQ-015 Register 0 SHALL always read 0; writes and pend_set to address 0 SHALL be ignored; busy for address 0 SHALL always be 0.
REQ-016 Read SHALL be combinational: rdataN = regs[raddrN], zero-latency.
REQ-017 Write-through bypass: when we=1, waddr=raddrN and waddr!=0, rdataN SHALL equal wdata in the same cycle.
REQ-018 pend_set=1 with pend_addr!=0 SHALL set pending[pend_addr] on the clock edge.
REQ-019 A committed write (REQ-014) SHALL clear pending[waddr] on the same edge.
REQ-020 Simultaneous pend_set and write to the same address SHALL leave the bit set (a new pending producer wins); the data write still commits.
REQ-021 Simultaneous pend_set and write to different addresses SHALL both take effect.
REQ-022 busyN SHALL be pending[raddrN], except 0 when a bypassing write to raddrN occurs in the same cycle (REQ-017) and pend_set does not target raddrN that cycle.
REQ-023 Both read ports SHALL operate independently; raddr1=raddr2 SHALL return identical data and busy.
REQ-024 No arithmetic is performed; wdata SHALL be stored unmodified, full 32 bits.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) clear all registers to 0 and all pending bits to 0.
REQ-026 During reset, rdata1/rdata2 SHALL read 0 and busy1/busy2 SHALL be 0 regardless of inputs; we and pend_set are ignored.
REQ-027 Reset deassertion SHALL take effect on the next clk rising edge; no other startup sequencing.
REQ-028 Reset asserted mid-operation SHALL discard all pending state; no write in flight survives.

Verification
REQ-029 Write/read: we=1, waddr=5, wdata=32'h00c0ffee, one edge; then raddr1=5 -> rdata1=32'h00c0ffee, busy1=0.
REQ-030 Zero register: we=1, waddr=0, wdata=32'hdeadbeef; raddr2=0 -> rdata2=0 before and after the edge.
REQ-031 Bypass: regs[7]=0, drive we=1, waddr=7, wdata=32'hbaadc0de, raddr1=7 -> rdata1=32'hbaadc0de in the same cycle, before the edge.
REQ-032 Scoreboard: pend_set on 9 -> next cycle busy1=1 for raddr1=9; write 9 with 32'h1234 -> busy1=0 in the write cycle, rdata1=32'h1234; one edge later, pending[9]=0.
REQ-033 Collision: pend_set on 9 and we=1 to 9 with 32'h5555 in the same cycle -> after the edge, rdata1=32'h5555 and busy1=1.
REQ-034 Async reset: populate regs 1..31 and pend 3; pull rst_n low between edges -> all rdata=0 and busy=0 immediately, and remain 0 after release until written.
